// File: rtl/mem_arbiter.sv
// Shared-memory arbiter between instruction fetch and data access ports.
// Data requests win over fetches; a wait counter aborts a bus cycle that never sees bus_ack.
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic [1:0]  d_rw,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [31:0] if_rdata,
    output logic [31:0] d_rdata,
    output logic        if_done,
    output logic        d_done,
    output logic        stall,
    output logic        bus_err
);

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        FETCH = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          bus_req_d;
    logic          bus_we_d;
    logic [AW-1:0] bus_addr_d;
    logic [DW-1:0] bus_wdata_d;
    logic [DW-1:0] if_rdata_d;
    logic [DW-1:0] d_rdata_d;
    logic          if_done_d;
    logic          d_done_d;
    logic          bus_err_d;

    logic          d_valid;
    logic          d_pending;
    logic          if_pending;

    // A requester whose done is showing this cycle is about to advance, so it is no longer pending.
    assign d_valid    = (d_rw == 2'b01) || (d_rw == 2'b10);
    assign d_pending  = d_valid && !d_done;
    assign if_pending = if_req && !if_done;
    assign stall      = d_pending || if_pending;

    // Next-state and next registered output values.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bus_req_d   = bus_req;
        bus_we_d    = bus_we;
        bus_addr_d  = bus_addr;
        bus_wdata_d = bus_wdata;
        if_rdata_d  = if_rdata;
        d_rdata_d   = d_rdata;
        if_done_d   = 1'b0;
        d_done_d    = 1'b0;
        bus_err_d   = bus_err;

        unique case (state_q)
            IDLE: begin
                if (d_pending) begin
                    state_d     = DATA;
                    cnt_d       = '0;
                    bus_req_d   = 1'b1;
                    bus_we_d    = d_rw[0];
                    bus_addr_d  = d_addr;
                    bus_wdata_d = d_wdata;
                end else if (if_pending) begin
                    state_d     = FETCH;
                    cnt_d       = '0;
                    bus_req_d   = 1'b1;
                    bus_we_d    = 1'b0;
                    bus_addr_d  = if_addr;
                    bus_wdata_d = '0;
                end
            end

            DATA, FETCH: begin
                if (bus_ack) begin
                    state_d   = IDLE;
                    bus_req_d = 1'b0;
                    if (state_q == DATA) begin
                        d_done_d = 1'b1;
                        if (!bus_we) begin
                            d_rdata_d = bus_rdata;
                        end
                    end else begin
                        if_done_d  = 1'b1;
                        if_rdata_d = bus_rdata;
                    end
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    // Abort: complete the requester with zero data and flag the error.
                    state_d   = IDLE;
                    bus_req_d = 1'b0;
                    bus_err_d = 1'b1;
                    if (state_q == DATA) begin
                        d_done_d  = 1'b1;
                        d_rdata_d = '0;
                    end else begin
                        if_done_d  = 1'b1;
                        if_rdata_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            default: begin
                state_d   = IDLE;
                bus_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            if_done   <= 1'b0;
            d_done    <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bus_req   <= bus_req_d;
            bus_we    <= bus_we_d;
            bus_addr  <= bus_addr_d;
            bus_wdata <= bus_wdata_d;
            if_rdata  <= if_rdata_d;
            d_rdata   <= d_rdata_d;
            if_done   <= if_done_d;
            d_done    <= d_done_d;
            bus_err   <= bus_err_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized transactions
// checked against a transaction-level expectation model.
module tb_mem_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [1:0]  d_rw;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] if_rdata;
    logic [31:0] d_rdata;
    logic        if_done;
    logic        d_done;
    logic        stall;
    logic        bus_err;

    int n_cmp = 0;
    int n_bad = 0;

    // Model of the values the arbiter should be holding.
    logic [31:0] exp_d;
    logic [31:0] exp_if;
    logic        exp_err;

    mem_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr),
        .d_rw(d_rw), .d_addr(d_addr), .d_wdata(d_wdata),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .if_rdata(if_rdata), .d_rdata(d_rdata),
        .if_done(if_done), .d_done(d_done),
        .stall(stall), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Every task starts and ends just after a rising edge.
    task automatic test_reset();
        rst = 1'b1; if_req = 1'b0; d_rw = 2'b00; bus_ack = 1'b0;
        if_addr = '0; d_addr = '0; d_wdata = '0; bus_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({bus_req, bus_we, bus_addr, bus_wdata, if_rdata, d_rdata, if_done, d_done, bus_err} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: req=%b we=%b addr=%h wdata=%h ifr=%h dr=%h ifd=%b dd=%b err=%b, required all zero",
                     bus_req, bus_we, bus_addr, bus_wdata, if_rdata, d_rdata, if_done, d_done, bus_err);
        end
        n_cmp++;
        if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b want 0", stall); end
        rst = 1'b0;
        exp_d = '0; exp_if = '0; exp_err = 1'b0;
    endtask

    // Present a data op and/or fetch, serve each resulting bus cycle with an ack after dly cycles
    // (dly >= TO means never), and check ordering, latency, bus fields, done pulses and data.
    task automatic test_txn(input string tag, input logic [1:0] rw, input logic fr,
                            input logic [31:0] ia, input logic [31:0] da, input logic [31:0] wd,
                            input logic [31:0] rd0, input logic [31:0] rd1,
                            input int dly0, input int dly1);
        logic is_data [2];
        int   n;
        n = 0;
        if (rw == 2'b01 || rw == 2'b10) begin is_data[n] = 1'b1; n++; end
        if (fr) begin is_data[n] = 1'b0; n++; end
        d_rw = rw; if_req = fr; if_addr = ia; d_addr = da; d_wdata = wd;

        if (n == 0) begin
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                n_cmp++;
                if (bus_req !== 1'b0 || stall !== 1'b0) begin
                    n_bad++;
                    $display("FAIL %s noop: bus_req=%b stall=%b, required 0/0", tag, bus_req, stall);
                end
            end
            d_rw = 2'b00; if_req = 1'b0;
            @(posedge clk); #1;
            return;
        end

        for (int k = 0; k < n; k++) begin
            int          dly;
            int          len;
            logic        tmo;
            logic [31:0] rd;
            logic [31:0] ea;
            logic [31:0] ewd;
            logic        ewe;
            dly = (k == 0) ? dly0 : dly1;
            rd  = (k == 0) ? rd0 : rd1;
            tmo = (dly >= TO);
            len = tmo ? TO : dly + 1;
            ea  = is_data[k] ? da : ia;
            ewe = is_data[k] ? rw[0] : 1'b0;
            ewd = (is_data[k] && rw[0]) ? wd : 32'h0;
            if (is_data[k] && !rw[0]) ewd = wd;
            if (!is_data[k]) ewd = 32'h0;

            if (k == 0) begin
                @(negedge clk);
                n_cmp++;
                if (bus_req !== 1'b0 || stall !== 1'b1) begin
                    n_bad++;
                    $display("FAIL %s latency: bus_req=%b stall=%b in request cycle, required 0/1", tag, bus_req, stall);
                end
            end
            @(negedge clk);
            for (int j = 0; j < len; j++) begin
                n_cmp++;
                if (bus_req !== 1'b1 || bus_addr !== ea || bus_we !== ewe ||
                    (ewe && bus_wdata !== ewd) || (!is_data[k] && bus_wdata !== 32'h0)) begin
                    n_bad++;
                    $display("FAIL %s busfields op%0d cyc%0d: req=%b addr=%h we=%b wdata=%h, required 1 %h %b %h",
                             tag, k, j, bus_req, bus_addr, bus_we, bus_wdata, ea, ewe, ewd);
                end
                n_cmp++;
                if (stall !== 1'b1 || d_done !== 1'b0 || if_done !== 1'b0) begin
                    n_bad++;
                    $display("FAIL %s waiting op%0d cyc%0d: stall=%b d_done=%b if_done=%b, required 1/0/0",
                             tag, k, j, stall, d_done, if_done);
                end
                bus_ack   = (j == dly);
                bus_rdata = (j == dly) ? rd : $urandom;
                @(negedge clk);
            end

            if (is_data[k]) begin
                if (tmo) exp_d = '0;
                else if (!rw[0]) exp_d = rd;
            end else begin
                exp_if = tmo ? 32'h0 : rd;
            end
            exp_err = exp_err | tmo;

            n_cmp++;
            if (bus_req !== 1'b0 || d_done !== is_data[k] || if_done !== !is_data[k]) begin
                n_bad++;
                $display("FAIL %s done op%0d: bus_req=%b d_done=%b if_done=%b, required 0 %b %b",
                         tag, k, bus_req, d_done, if_done, is_data[k], !is_data[k]);
            end
            n_cmp++;
            if (d_rdata !== exp_d || if_rdata !== exp_if || bus_err !== exp_err) begin
                n_bad++;
                $display("FAIL %s data op%0d: d_rdata=%h if_rdata=%h err=%b, required %h %h %b",
                         tag, k, d_rdata, if_rdata, bus_err, exp_d, exp_if, exp_err);
            end
            n_cmp++;
            if (stall !== (k < n - 1)) begin
                n_bad++;
                $display("FAIL %s done_stall op%0d: stall=%b required %b", tag, k, stall, (k < n - 1));
            end
            @(posedge clk); #1;
            bus_ack = 1'b0;
            if (is_data[k]) d_rw = 2'b00;
            else if_req = 1'b0;
        end

        @(negedge clk);
        n_cmp++;
        if (d_done !== 1'b0 || if_done !== 1'b0 || bus_req !== 1'b0 || stall !== 1'b0) begin
            n_bad++;
            $display("FAIL %s after: d_done=%b if_done=%b bus_req=%b stall=%b, required all 0",
                     tag, d_done, if_done, bus_req, stall);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_fetch();
        test_txn("fetch", 2'b00, 1'b1, 32'h100, 32'h0, 32'h0, 32'hDEADBEEF, 32'h0, 3, 0);
    endtask

    task automatic test_contention();
        test_txn("contention", 2'b10, 1'b1, 32'h180, 32'h200, 32'hAAAA5555, 32'hCAFEF00D, 32'h0BADF00D, 1, 2);
    endtask

    task automatic test_store();
        test_txn("store", 2'b01, 1'b0, 32'h0, 32'h40, 32'h12345678, 32'hFFFF0000, 32'h0, 0, 0);
    endtask

    task automatic test_noop();
        test_txn("noop11", 2'b11, 1'b0, 32'h0, 32'h300, 32'h1, 32'h0, 32'h0, 0, 0);
        test_txn("noop11_fetch", 2'b11, 1'b1, 32'h340, 32'h300, 32'h1, 32'h13572468, 32'h0, 1, 0);
    endtask

    task automatic test_idle_ack();
        for (int c = 0; c < 3; c++) begin
            bus_ack = 1'b1; bus_rdata = $urandom;
            @(negedge clk);
            n_cmp++;
            if (bus_req !== 1'b0 || d_done !== 1'b0 || if_done !== 1'b0 ||
                d_rdata !== exp_d || if_rdata !== exp_if) begin
                n_bad++;
                $display("FAIL idle_ack: req=%b dd=%b ifd=%b dr=%h ifr=%h, required 0 0 0 %h %h",
                         bus_req, d_done, if_done, d_rdata, if_rdata, exp_d, exp_if);
            end
            @(posedge clk); #1;
        end
        bus_ack = 1'b0;
    endtask

    task automatic test_withdraw();
        logic [31:0] rd;
        rd = $urandom;
        d_rw = 2'b10; d_addr = 32'h5C0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (bus_req !== 1'b1) begin n_bad++; $display("FAIL withdraw_start: bus_req=%b want 1", bus_req); end
        d_rw = 2'b00;
        @(negedge clk);
        n_cmp++;
        if (bus_req !== 1'b1 || bus_addr !== 32'h5C0 || stall !== 1'b0) begin
            n_bad++;
            $display("FAIL withdraw_hold: req=%b addr=%h stall=%b, required 1 000005c0 0", bus_req, bus_addr, stall);
        end
        bus_ack = 1'b1; bus_rdata = rd;
        @(negedge clk);
        bus_ack = 1'b0;
        exp_d = rd;
        n_cmp++;
        if (d_done !== 1'b1 || d_rdata !== exp_d || bus_req !== 1'b0) begin
            n_bad++;
            $display("FAIL withdraw_done: d_done=%b d_rdata=%h req=%b, required 1 %h 0", d_done, d_rdata, bus_req, exp_d);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_timeout();
        test_txn("timeout_rd", 2'b10, 1'b0, 32'h0, 32'h700, 32'h0, 32'h11111111, 32'h0, 9, 0);
        test_txn("timeout_if", 2'b00, 1'b1, 32'h704, 32'h0, 32'h0, 32'h22222222, 32'h0, TO, 0);
        test_txn("after_tmo", 2'b10, 1'b0, 32'h0, 32'h708, 32'h0, 32'h33333333, 32'h0, 0, 0);
    endtask

    task automatic test_reset_mid();
        d_rw = 2'b10; d_addr = 32'h900;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (bus_req !== 1'b1) begin n_bad++; $display("FAIL rstmid_start: bus_req=%b want 1", bus_req); end
        rst = 1'b1; bus_ack = 1'b1; bus_rdata = 32'h5A5A5A5A;
        @(posedge clk); #1;
        rst = 1'b0; bus_ack = 1'b0; d_rw = 2'b00;
        exp_d = '0; exp_if = '0; exp_err = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus_req !== 1'b0 || d_done !== 1'b0 || d_rdata !== 32'h0 || bus_err !== 1'b0) begin
            n_bad++;
            $display("FAIL rstmid: req=%b d_done=%b d_rdata=%h err=%b, required 0 0 0 0", bus_req, d_done, d_rdata, bus_err);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        for (int it = 0; it < 25; it++) begin
            logic [1:0] rw;
            logic       fr;
            rw = 2'($urandom_range(0, 3));
            fr = 1'($urandom_range(0, 1));
            test_txn($sformatf("rand%0d", it), rw, fr, $urandom, $urandom, $urandom,
                     $urandom, $urandom, $urandom_range(0, 5), $urandom_range(0, 5));
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_contention();
        test_store();
        test_noop();
        test_idle_ack();
        test_withdraw();
        test_timeout();
        test_reset_mid();
        test_random();
        test_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
